// File: rtl/jtag_vec_sequencer.sv
// jtag_vec_sequencer: splits one XVC shift command into engine runs of up to
// 32 bits. It returns one captured TDO word per run. A watchdog aborts the
// command when the engine never reports completion.
module jtag_vec_sequencer #(
  parameter int C_LEN_WIDTH    = 32,   // must be at least 6 so a full 32-bit run fits in rem
  parameter int C_DONE_TIMEOUT = 4096  // 0 disables the watchdog
) (
  input  logic                   s_axi_aclk,
  input  logic                   s_axi_aresetn,
  input  logic                   hdr_valid_i,
  output logic                   hdr_ready_o,
  input  logic [C_LEN_WIDTH-1:0] hdr_nbits_i,
  input  logic                   vec_valid_i,
  output logic                   vec_ready_o,
  input  logic [31:0]            vec_tms_i,
  input  logic [31:0]            vec_tdi_i,
  output logic                   tdo_valid_o,
  input  logic                   tdo_ready_i,
  output logic [31:0]            tdo_data_o,
  output logic                   tdo_last_o,
  output logic                   tdo_err_o,
  output logic                   jtag_en_o,
  output logic [31:0]            jtag_len_o,
  output logic [31:0]            jtag_tms_o,
  output logic [31:0]            jtag_tdi_o,
  input  logic [31:0]            jtag_tdo_i,
  input  logic                   jtag_done_i,
  output logic                   busy_o,
  output logic                   err_o,
  input  logic                   err_clr_i
);

  localparam int WD_W = (C_DONE_TIMEOUT > 1) ? $clog2(C_DONE_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (C_DONE_TIMEOUT > 0) ? WD_W'(C_DONE_TIMEOUT - 1) : '0;

  // SETUP holds the loaded vectors steady for three edges before the engine
  // starts. This gives the minimum handshake-to-enable latency and a long low
  // time on jtag_en_o between runs.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETUP,
    ST_SHIFT,
    ST_OUT,
    ST_FLUSH
  } state_t;

  state_t                 state, state_nxt;
  logic [C_LEN_WIDTH-1:0] rem;
  logic [C_LEN_WIDTH-1:0] rem_after;
  logic [5:0]             run_len;
  logic [5:0]             len_q;
  logic [1:0]             setup_cnt;
  logic [WD_W-1:0]        wd_cnt;
  logic                   aborted;

  logic hdr_fire, vec_fire, tdo_fire, done_hit, wd_fire;

  assign hdr_ready_o = (state == ST_IDLE);
  assign vec_ready_o = (state == ST_LOAD) || (state == ST_FLUSH);
  assign busy_o      = (state != ST_IDLE);
  assign jtag_len_o  = {26'd0, len_q};

  assign hdr_fire = hdr_valid_i && hdr_ready_o;
  assign vec_fire = vec_valid_i && vec_ready_o;
  assign tdo_fire = tdo_valid_o && tdo_ready_i;
  assign done_hit = (state == ST_SHIFT) && jtag_done_i;
  // Completion on the timeout edge counts as success.
  assign wd_fire  = (C_DONE_TIMEOUT > 0) && (state == ST_SHIFT) && !jtag_done_i &&
                    (wd_cnt == WD_LAST);

  // Size of the next run: min(rem, 32). rem never wraps when this is subtracted.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first; a path that leaves it unassigned infers a latch.
    run_len = 6'd32;
    if (rem < C_LEN_WIDTH'(32)) run_len = rem[5:0];
    rem_after = rem - C_LEN_WIDTH'(run_len);
  end

  // State register.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!s_axi_aresetn) state <= ST_IDLE;
    else                state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (hdr_fire && (hdr_nbits_i != '0)) state_nxt = ST_LOAD;
      ST_LOAD:  if (vec_fire) state_nxt = ST_SETUP;
      ST_SETUP: if (setup_cnt == 2'd0) state_nxt = ST_SHIFT;
      ST_SHIFT: if (done_hit || wd_fire) state_nxt = ST_OUT;
      ST_OUT: begin
        if (tdo_fire) begin
          if (aborted)         state_nxt = (rem != '0) ? ST_FLUSH : ST_IDLE;
          else if (tdo_last_o) state_nxt = ST_IDLE;
          else                 state_nxt = ST_LOAD;
        end
      end
      ST_FLUSH: if (vec_fire && (rem_after == '0)) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Command datapath: remaining bits, engine vectors, watchdog and TDO output word.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      rem         <= '0;
      len_q       <= '0;
      jtag_tms_o  <= '0;
      jtag_tdi_o  <= '0;
      jtag_en_o   <= 1'b0;
      setup_cnt   <= '0;
      wd_cnt      <= '0;
      aborted     <= 1'b0;
      tdo_valid_o <= 1'b0;
      tdo_data_o  <= '0;
      tdo_last_o  <= 1'b0;
      tdo_err_o   <= 1'b0;
    end else begin
      if (hdr_fire) rem <= hdr_nbits_i;

      if (vec_fire) begin
        rem <= rem_after;
        // Flushed words only drain the bit count; they never reach the engine.
        if (state == ST_LOAD) begin
          len_q      <= run_len;
          jtag_tms_o <= vec_tms_i;
          jtag_tdi_o <= vec_tdi_i;
          setup_cnt  <= 2'd2;
        end
      end

      if (state == ST_SETUP) begin
        if (setup_cnt == 2'd0) begin
          jtag_en_o <= 1'b1;
          wd_cnt    <= '0;
        end else begin
          setup_cnt <= setup_cnt - 2'd1;
        end
      end

      if (done_hit) begin
        jtag_en_o   <= 1'b0;
        tdo_valid_o <= 1'b1;
        tdo_data_o  <= jtag_tdo_i;
        tdo_last_o  <= (rem == '0);
        tdo_err_o   <= 1'b0;
      end else if (wd_fire) begin
        jtag_en_o   <= 1'b0;
        aborted     <= 1'b1;
        tdo_valid_o <= 1'b1;
        tdo_data_o  <= '0;
        tdo_last_o  <= 1'b1;
        tdo_err_o   <= 1'b1;
      end else if (state == ST_SHIFT) begin
        wd_cnt <= wd_cnt + 1'b1;
      end

      if (tdo_fire) begin
        tdo_valid_o <= 1'b0;
        tdo_last_o  <= 1'b0;
        tdo_err_o   <= 1'b0;
        aborted     <= 1'b0;
      end
    end
  end

  // Sticky watchdog flag; a new abort beats a simultaneous clear.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn)  err_o <= 1'b0;
    else if (wd_fire)    err_o <= 1'b1;
    else if (err_clr_i)  err_o <= 1'b0;
  end

endmodule

// File: tb/tb_jtag_vec_sequencer.sv
// tb_jtag_vec_sequencer: randomized command stream with a behavioural JTAG
// engine. The expected run lengths and TDO words come from the command
// arithmetic and from the engine's own responses.
module tb_jtag_vec_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [31:0] hdr_nbits;
  logic        vec_valid;
  logic        vec_ready;
  logic [31:0] vec_tms;
  logic [31:0] vec_tdi;
  logic        tdo_valid;
  logic        tdo_ready;
  logic [31:0] tdo_data;
  logic        tdo_last;
  logic        tdo_err;
  logic        jtag_en;
  logic [31:0] jtag_len;
  logic [31:0] jtag_tms;
  logic [31:0] jtag_tdi;
  logic [31:0] jtag_tdo;
  logic        jtag_done;
  logic        busy;
  logic        err;
  logic        err_clr;

  int checks = 0;
  int errors = 0;

  // Engine control and record of what the engine saw and returned.
  bit          engine_mute = 1'b0;
  bit          eng_force   = 1'b0;
  logic [31:0] eng_force_val = '0;
  logic [31:0] run_len_q[$];
  logic [31:0] run_tms_q[$];
  logic [31:0] run_tdi_q[$];
  logic [31:0] eng_tdo_q[$];

  jtag_vec_sequencer #(.C_LEN_WIDTH(32), .C_DONE_TIMEOUT(16)) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .hdr_valid_i   (hdr_valid),
    .hdr_ready_o   (hdr_ready),
    .hdr_nbits_i   (hdr_nbits),
    .vec_valid_i   (vec_valid),
    .vec_ready_o   (vec_ready),
    .vec_tms_i     (vec_tms),
    .vec_tdi_i     (vec_tdi),
    .tdo_valid_o   (tdo_valid),
    .tdo_ready_i   (tdo_ready),
    .tdo_data_o    (tdo_data),
    .tdo_last_o    (tdo_last),
    .tdo_err_o     (tdo_err),
    .jtag_en_o     (jtag_en),
    .jtag_len_o    (jtag_len),
    .jtag_tms_o    (jtag_tms),
    .jtag_tdi_o    (jtag_tdi),
    .jtag_tdo_i    (jtag_tdo),
    .jtag_done_i   (jtag_done),
    .busy_o        (busy),
    .err_o         (err),
    .err_clr_i     (err_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] flags();
    return {hdr_ready, vec_ready, tdo_valid, tdo_last, tdo_err, jtag_en, busy, err};
  endfunction

  // Behavioural engine: after a random delay, answers each run with a one-cycle done pulse.
  initial begin
    logic [31:0] rsp;
    jtag_done = 1'b0;
    jtag_tdo  = '0;
    forever begin
      @(negedge clk);
      if (jtag_en === 1'b1) begin
        if (engine_mute) begin
          while (jtag_en === 1'b1) @(negedge clk);
        end else begin
          run_len_q.push_back(jtag_len);
          run_tms_q.push_back(jtag_tms);
          run_tdi_q.push_back(jtag_tdi);
          repeat ($urandom_range(0, 6)) @(negedge clk);
          rsp = eng_force ? eng_force_val : $urandom;
          jtag_tdo  = rsp;
          jtag_done = 1'b1;
          eng_tdo_q.push_back(rsp);
          @(negedge clk);
          jtag_done = 1'b0;
          jtag_tdo  = $urandom;
        end
      end
    end
  end

  // Between two engine runs, jtag_en must stay low for at least two cycles.
  initial begin
    bit en_prev  = 1'b0;
    bit have_run = 1'b0;
    int gap      = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        en_prev  = 1'b0;
        have_run = 1'b0;
      end else begin
        if (jtag_en === 1'b1 && !en_prev && have_run) begin
          checks++;
          if (gap < 2) begin
            errors++;
            $display("FAIL en_gap low_cycles=%0d required>=2", gap);
          end
        end
        if (jtag_en !== 1'b1 && en_prev) begin
          gap      = 1;
          have_run = 1'b1;
        end else if (jtag_en !== 1'b1) begin
          gap++;
        end
        en_prev = (jtag_en === 1'b1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  task automatic send_hdr(input logic [31:0] nbits, input string tag);
    hdr_valid = 1'b1;
    hdr_nbits = nbits;
    checks++;
    if (hdr_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s hdr_ready got=%b want=1", tag, hdr_ready);
    end
    @(negedge clk);
    hdr_valid = 1'b0;
  endtask

  task automatic send_vec(input logic [31:0] tms, input logic [31:0] tdi, input string tag,
                          output bit ok);
    int n = 0;
    vec_valid = 1'b1;
    vec_tms   = tms;
    vec_tdi   = tdi;
    while (vec_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL %s vec_handshake got=no_ready want=ready_within_50", tag);
      ok = 1'b0;
    end else begin
      @(negedge clk);
      ok = 1'b1;
    end
    vec_valid = 1'b0;
  endtask

  task automatic accept_tdo();
    tdo_ready = 1'b1;
    @(negedge clk);
    tdo_ready = 1'b0;
  endtask

  // Full command with random or fixed vectors; stall holds tdo_ready low in OUT.
  task automatic run_cmd(input logic [31:0] nbits, input int stall, input bit fixed,
                         input logic [31:0] f_tms, input logic [31:0] f_tdi, input string tag);
    logic [31:0] rem;
    int          nwords;
    rem    = nbits;
    nwords = int'((nbits + 32'd31) / 32'd32);
    send_hdr(nbits, tag);
    for (int w = 0; w < nwords; w++) begin
      logic [31:0] tms, tdi, exp_tdo, r_len, r_tms, r_tdi, held_data;
      logic        held_last;
      int          exp_len, lat, n;
      bit          ok;
      tms     = fixed ? f_tms : $urandom;
      tdi     = fixed ? f_tdi : $urandom;
      exp_len = (rem > 32) ? 32 : int'(rem);
      rem     = rem - 32'(exp_len);
      send_vec(tms, tdi, tag, ok);
      if (!ok) return;
      lat = 0;
      while (jtag_en !== 1'b1 && lat < 50) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat < 3 || lat >= 50) begin
        errors++;
        $display("FAIL %s en_latency got=%0d want=3..49", tag, lat);
      end
      n = 0;
      while (tdo_valid !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n >= 50) begin
        errors++;
        $display("FAIL %s tdo_valid_timeout got=0 want=1", tag);
        return;
      end
      checks++;
      if (run_len_q.size() == 0 || eng_tdo_q.size() == 0) begin
        errors++;
        $display("FAIL %s engine_run got=none want=len%0d", tag, exp_len);
        return;
      end
      r_len   = run_len_q.pop_front();
      r_tms   = run_tms_q.pop_front();
      r_tdi   = run_tdi_q.pop_front();
      exp_tdo = eng_tdo_q.pop_front();
      if ({r_len, r_tms, r_tdi} !== {32'(exp_len), tms, tdi}) begin
        errors++;
        $display("FAIL %s run%0d got len=%0d tms=%h tdi=%h want len=%0d tms=%h tdi=%h",
                 tag, w, r_len, r_tms, r_tdi, exp_len, tms, tdi);
      end
      checks++;
      if ({tdo_data, tdo_last, tdo_err} !== {exp_tdo, (w == nwords - 1), 1'b0}) begin
        errors++;
        $display("FAIL %s tdo%0d got data=%h last=%b err=%b want data=%h last=%b err=0",
                 tag, w, tdo_data, tdo_last, tdo_err, exp_tdo, (w == nwords - 1));
      end
      held_data = tdo_data;
      held_last = tdo_last;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        checks++;
        if ({tdo_data, tdo_last, tdo_valid, jtag_en, vec_ready} !==
            {held_data, held_last, 1'b1, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL %s stall%0d got data=%h last=%b valid=%b en=%b vrdy=%b want data=%h last=%b valid=1 en=0 vrdy=0",
                   tag, s, tdo_data, tdo_last, tdo_valid, jtag_en, vec_ready, held_data, held_last);
        end
      end
      accept_tdo();
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_after got=%b want=0", tag, busy);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (flags() !== 8'b1000_0000 || {tdo_data, jtag_len, jtag_tms, jtag_tdi} !== '0) begin
      errors++;
      $display("FAIL reset_hold flags got=%b want=10000000", flags());
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (flags() !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_release flags got=%b want=10000000", flags());
    end
  endtask

  task automatic test_zero_len();
    send_hdr(32'd0, "zero_len");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({vec_ready, tdo_valid, busy} !== 3'b000) begin
        errors++;
        $display("FAIL zero_len cycle%0d got vrdy/tvld/busy=%b want=000", i,
                 {vec_ready, tdo_valid, busy});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single();
    eng_force     = 1'b1;
    eng_force_val = 32'h15;
    run_cmd(32'd5, 0, 1'b1, 32'h1F, 32'h0A, "single");
    eng_force     = 1'b0;
  endtask

  task automatic test_multi_run();
    run_cmd(32'd70, 0, 1'b0, '0, '0, "multi70");
  endtask

  task automatic test_stall();
    run_cmd(32'd40, 10, 1'b0, '0, '0, "stall");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_cmd(32'($urandom_range(1, 130)), $urandom_range(0, 3), 1'b0, '0, '0, "random");
    end
  endtask

  task automatic test_watchdog();
    int hi = 0;
    int n  = 0;
    bit ok;
    engine_mute = 1'b1;
    send_hdr(32'd64, "wd");
    send_vec($urandom, $urandom, "wd", ok);
    while (jtag_en !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    while (jtag_en === 1'b1 && hi < 100) begin
      @(negedge clk);
      hi++;
    end
    checks++;
    if (hi != 16) begin
      errors++;
      $display("FAIL wd_en_cycles got=%0d want=16", hi);
    end
    checks++;
    if ({tdo_valid, tdo_data, tdo_last, tdo_err, err} !== {1'b1, 32'h0, 1'b1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL wd_err_word got vld=%b data=%h last=%b terr=%b err=%b want 1 0 1 1 1",
               tdo_valid, tdo_data, tdo_last, tdo_err, err);
    end
    accept_tdo();
    checks++;
    if ({vec_ready, busy, jtag_en} !== 3'b110) begin
      errors++;
      $display("FAIL wd_flush_state got vrdy/busy/en=%b want=110", {vec_ready, busy, jtag_en});
    end
    send_vec($urandom, $urandom, "wd_flush", ok);
    checks++;
    if ({busy, jtag_en, tdo_valid, err} !== 4'b0001) begin
      errors++;
      $display("FAIL wd_after_flush got busy/en/tvld/err=%b want=0001",
               {busy, jtag_en, tdo_valid, err});
    end
    repeat (5) @(negedge clk);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL wd_sticky got=%b want=1", err);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL wd_clear got=%b want=0", err);
    end
    engine_mute = 1'b0;
  endtask

  task automatic test_mid_reset();
    int n = 0;
    bit ok;
    engine_mute = 1'b1;
    send_hdr(32'd40, "midrst");
    send_vec($urandom, $urandom, "midrst", ok);
    while (jtag_en !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (flags() !== 8'b1000_0000 || {tdo_data, jtag_len, jtag_tms, jtag_tdi} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs flags got=%b want=10000000", flags());
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_len_q.delete();
    run_tms_q.delete();
    run_tdi_q.delete();
    eng_tdo_q.delete();
    engine_mute = 1'b0;
    run_cmd(32'd8, 0, 1'b0, '0, '0, "after_rst");
  endtask

  initial begin
    rst_n     = 1'b0;
    hdr_valid = 1'b0;
    hdr_nbits = '0;
    vec_valid = 1'b0;
    vec_tms   = '0;
    vec_tdi   = '0;
    tdo_ready = 1'b0;
    err_clr   = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_zero_len();
    test_single();
    test_multi_run();
    test_stall();
    test_watchdog();
    test_mid_reset();
    test_random();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
